dbg_bus_arbiter: RTL and testbench

//   Shares one OBI-style data memory port between two requesters: core data port (port 0) and

---
 rtl/dbg_bus_arbiter.sv | 153 +++++++++++++++
 tb/tb_dbg_bus_arbiter.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/dbg_bus_arbiter.sv
// Two-port arbiter sharing one OBI-style data memory port between the core
// data port (port 0) and the debug-module system bus master (port 1).
// Requests are granted in the same cycle the memory accepts them, and the
// issuer of each accepted request is queued so that in-order responses can be
// routed back to the right requester.
module dbg_bus_arbiter #(
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned MaxOutstanding = 2,
  parameter int unsigned SbaFixedPrio   = 0
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  // core data port
  input  logic                   core_req_i,
  input  logic [AddrWidth-1:0]   core_addr_i,
  input  logic                   core_we_i,
  input  logic [DataWidth/8-1:0] core_be_i,
  input  logic [DataWidth-1:0]   core_wdata_i,
  output logic                   core_gnt_o,
  output logic                   core_rvalid_o,
  output logic [DataWidth-1:0]   core_rdata_o,
  // debug system bus master port
  input  logic                   sb_req_i,
  input  logic [AddrWidth-1:0]   sb_addr_i,
  input  logic                   sb_we_i,
  input  logic [DataWidth/8-1:0] sb_be_i,
  input  logic [DataWidth-1:0]   sb_wdata_i,
  output logic                   sb_gnt_o,
  output logic                   sb_rvalid_o,
  output logic [DataWidth-1:0]   sb_rdata_o,
  // memory port
  output logic                   m_req_o,
  output logic [AddrWidth-1:0]   m_addr_o,
  output logic                   m_we_o,
  output logic [DataWidth/8-1:0] m_be_o,
  output logic [DataWidth-1:0]   m_wdata_o,
  input  logic                   m_gnt_i,
  input  logic                   m_rvalid_i,
  input  logic [DataWidth-1:0]   m_rdata_i,
  output logic                   unexp_rvalid_o
);

  localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);
  localparam int unsigned PtrWidth = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

  typedef enum logic {
    PORT_CORE = 1'b0,
    PORT_SBA  = 1'b1
  } port_e;

  port_e                id_q [MaxOutstanding];
  logic [PtrWidth-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntWidth-1:0]  cnt_q;
  logic                 lock_q, lock_d;
  port_e                lock_port_q, last_grant_q;

  logic                 core_req, sb_req, m_rvalid;
  logic                 full, empty;
  port_e                sel, head;
  logic                 sel_req, grant, push, pop;

  function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
    return (p == PtrWidth'(MaxOutstanding - 1)) ? '0 : p + PtrWidth'(1);
  endfunction

  // Selection, memory request/payload mux, grant and response routing.
  // Inputs are qualified with rst_ni so every output is 0 while reset is held,
  // not just after the next clock edge.
  always_comb begin
    core_req = core_req_i & rst_ni;
    sb_req   = sb_req_i & rst_ni;
    m_rvalid = m_rvalid_i & rst_ni;
    full     = (cnt_q == CntWidth'(MaxOutstanding));
    empty    = (cnt_q == '0);
    head     = id_q[rd_ptr_q];

    sel = PORT_CORE;
    if (lock_q)                      sel = lock_port_q;
    else if (core_req && !sb_req)    sel = PORT_CORE;
    else if (!core_req && sb_req)    sel = PORT_SBA;
    else if (core_req && sb_req)
      sel = (SbaFixedPrio != 0) ? PORT_SBA
          : ((last_grant_q == PORT_SBA) ? PORT_CORE : PORT_SBA);

    sel_req = (sel == PORT_SBA) ? sb_req : core_req;
    m_req_o = sel_req & ~full;
    grant   = m_req_o & m_gnt_i;
    push    = grant;
    pop     = m_rvalid & ~empty;

    m_addr_o  = '0;
    m_we_o    = 1'b0;
    m_be_o    = '0;
    m_wdata_o = '0;
    if (sel_req) begin
      if (sel == PORT_SBA) begin
        m_addr_o  = sb_addr_i;
        m_we_o    = sb_we_i;
        m_be_o    = sb_be_i;
        m_wdata_o = sb_wdata_i;
      end else begin
        m_addr_o  = core_addr_i;
        m_we_o    = core_we_i;
        m_be_o    = core_be_i;
        m_wdata_o = core_wdata_i;
      end
    end

    core_gnt_o     = grant & (sel == PORT_CORE);
    sb_gnt_o       = grant & (sel == PORT_SBA);
    core_rvalid_o  = pop & (head == PORT_CORE);
    sb_rvalid_o    = pop & (head == PORT_SBA);
    core_rdata_o   = core_rvalid_o ? m_rdata_i : '0;
    sb_rdata_o     = sb_rvalid_o ? m_rdata_i : '0;
    unexp_rvalid_o = m_rvalid & empty;

    // Freeze selection while a request waits for the memory, or while the
    // selected port keeps requesting against a full ID queue.
    lock_d = ~grant & ((m_req_o & ~m_gnt_i) | (lock_q & full & sel_req));
  end

  // Selection lock and round-robin history.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q       <= 1'b0;
      lock_port_q  <= PORT_CORE;
      last_grant_q <= PORT_SBA;
    end else begin
      lock_q <= lock_d;
      if (lock_d && !lock_q) lock_port_q <= sel;
      if (grant)             last_grant_q <= sel;
    end
  end

  // In-order ID queue of outstanding transactions.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < MaxOutstanding; i++) id_q[i] <= PORT_CORE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) begin
        id_q[wr_ptr_q] <= sel;
        wr_ptr_q       <= ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      cnt_q <= cnt_q + CntWidth'(push) - CntWidth'(pop);
    end
  end

endmodule

// File: tb/tb_dbg_bus_arbiter.sv
// Directed bench for dbg_bus_arbiter: round-robin instance (dut) plus a
// fixed-priority instance (dut_fp) sharing the same stimulus.
module tb_dbg_bus_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        core_req_i = 1'b0, sb_req_i = 1'b0;
  logic [31:0] core_addr_i = '0, sb_addr_i = '0;
  logic        core_we_i = 1'b0, sb_we_i = 1'b1;
  logic [3:0]  core_be_i = 4'hF, sb_be_i = 4'h3;
  logic [31:0] core_wdata_i = 32'h1111_1111, sb_wdata_i = 32'h2222_2222;
  logic        m_gnt_i = 1'b0, m_rvalid_i = 1'b0;
  logic [31:0] m_rdata_i = '0;

  logic        core_gnt_o, core_rvalid_o, sb_gnt_o, sb_rvalid_o;
  logic [31:0] core_rdata_o, sb_rdata_o, m_addr_o, m_wdata_o;
  logic        m_req_o, m_we_o, unexp_rvalid_o;
  logic [3:0]  m_be_o;

  logic        fp_core_gnt, fp_core_rvalid, fp_sb_gnt, fp_sb_rvalid;
  logic [31:0] fp_core_rdata, fp_sb_rdata, fp_m_addr, fp_m_wdata;
  logic        fp_m_req, fp_m_we, fp_unexp;
  logic [3:0]  fp_m_be;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  dbg_bus_arbiter #(.AddrWidth(32), .DataWidth(32), .MaxOutstanding(2), .SbaFixedPrio(0)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .core_req_i(core_req_i), .core_addr_i(core_addr_i), .core_we_i(core_we_i),
    .core_be_i(core_be_i), .core_wdata_i(core_wdata_i),
    .core_gnt_o(core_gnt_o), .core_rvalid_o(core_rvalid_o), .core_rdata_o(core_rdata_o),
    .sb_req_i(sb_req_i), .sb_addr_i(sb_addr_i), .sb_we_i(sb_we_i),
    .sb_be_i(sb_be_i), .sb_wdata_i(sb_wdata_i),
    .sb_gnt_o(sb_gnt_o), .sb_rvalid_o(sb_rvalid_o), .sb_rdata_o(sb_rdata_o),
    .m_req_o(m_req_o), .m_addr_o(m_addr_o), .m_we_o(m_we_o), .m_be_o(m_be_o),
    .m_wdata_o(m_wdata_o), .m_gnt_i(m_gnt_i), .m_rvalid_i(m_rvalid_i),
    .m_rdata_i(m_rdata_i), .unexp_rvalid_o(unexp_rvalid_o)
  );

  dbg_bus_arbiter #(.AddrWidth(32), .DataWidth(32), .MaxOutstanding(2), .SbaFixedPrio(1)) dut_fp (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .core_req_i(core_req_i), .core_addr_i(core_addr_i), .core_we_i(core_we_i),
    .core_be_i(core_be_i), .core_wdata_i(core_wdata_i),
    .core_gnt_o(fp_core_gnt), .core_rvalid_o(fp_core_rvalid), .core_rdata_o(fp_core_rdata),
    .sb_req_i(sb_req_i), .sb_addr_i(sb_addr_i), .sb_we_i(sb_we_i),
    .sb_be_i(sb_be_i), .sb_wdata_i(sb_wdata_i),
    .sb_gnt_o(fp_sb_gnt), .sb_rvalid_o(fp_sb_rvalid), .sb_rdata_o(fp_sb_rdata),
    .m_req_o(fp_m_req), .m_addr_o(fp_m_addr), .m_we_o(fp_m_we), .m_be_o(fp_m_be),
    .m_wdata_o(fp_m_wdata), .m_gnt_i(m_gnt_i), .m_rvalid_i(m_rvalid_i),
    .m_rdata_i(m_rdata_i), .unexp_rvalid_o(fp_unexp)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of stimulus on the falling edge, then settle before checks.
  task automatic apply(input logic rst, input logic cr, input logic [31:0] ca,
                       input logic sr, input logic [31:0] sa, input logic g,
                       input logic rv, input logic [31:0] rd);
    @(negedge clk_i);
    rst_ni      = rst;
    core_req_i  = cr;
    core_addr_i = ca;
    sb_req_i    = sr;
    sb_addr_i   = sa;
    m_gnt_i     = g;
    m_rvalid_i  = rv;
    m_rdata_i   = rd;
    #1;
  endtask

  initial begin
    // Reset state
    #1;
    check_eq("rst_m_req",   64'(m_req_o), 64'h0);
    check_eq("rst_gnts",    64'({core_gnt_o, sb_gnt_o}), 64'h0);
    check_eq("rst_rvalids", 64'({core_rvalid_o, sb_rvalid_o, unexp_rvalid_o}), 64'h0);
    check_eq("rst_rdata",   64'(core_rdata_o | sb_rdata_o), 64'h0);
    repeat (2) @(negedge clk_i);

    // 1: core only, response one cycle later
    apply(1, 1, 32'h100, 0, 0, 1, 0, 0);
    check_eq("t1_core_gnt", 64'(core_gnt_o), 64'h1);
    check_eq("t1_m_addr",   64'(m_addr_o), 64'h100);
    check_eq("t1_m_we_be",  64'({m_we_o, m_be_o}), 64'h0F);
    check_eq("t1_sb_gnt",   64'(sb_gnt_o), 64'h0);
    apply(1, 0, 0, 0, 0, 1, 1, 32'hDEAD_BEEF);
    check_eq("t1_core_rvalid", 64'(core_rvalid_o), 64'h1);
    check_eq("t1_core_rdata",  64'(core_rdata_o), 64'hDEAD_BEEF);
    check_eq("t1_sb_out",      64'({sb_rvalid_o, sb_gnt_o, sb_rdata_o}), 64'h0);
    check_eq("t1_unexp",       64'(unexp_rvalid_o), 64'h0);

    // 2: both requesting; last grant was core, so round-robin starts with SBA
    apply(1, 1, 32'h10, 1, 32'h20, 1, 0, 0);
    check_eq("t2_rr0", 64'({core_gnt_o, sb_gnt_o}), 64'h1);
    check_eq("t2_fp0", 64'({fp_core_gnt, fp_sb_gnt}), 64'h1);
    apply(1, 1, 32'h10, 1, 32'h20, 1, 1, 32'h5);
    check_eq("t2_rr1", 64'({core_gnt_o, sb_gnt_o}), 64'h2);
    check_eq("t2_fp1", 64'({fp_core_gnt, fp_sb_gnt}), 64'h1);
    check_eq("t2_rv1", 64'({core_rvalid_o, sb_rvalid_o}), 64'h1);
    apply(1, 1, 32'h10, 1, 32'h20, 1, 1, 32'h6);
    check_eq("t2_rr2", 64'({core_gnt_o, sb_gnt_o}), 64'h1);
    check_eq("t2_fp2", 64'({fp_core_gnt, fp_sb_gnt}), 64'h1);
    check_eq("t2_rv2", 64'({core_rvalid_o, sb_rvalid_o}), 64'h2);
    apply(1, 1, 32'h10, 1, 32'h20, 1, 1, 32'h7);
    check_eq("t2_rr3", 64'({core_gnt_o, sb_gnt_o}), 64'h2);
    check_eq("t2_fp3", 64'({fp_core_gnt, fp_sb_gnt}), 64'h1);
    apply(1, 1, 32'h10, 0, 0, 1, 1, 32'h8);
    check_eq("t2_fp_core_after_sb_drop", 64'({fp_core_gnt, fp_sb_gnt}), 64'h2);
    check_eq("t2_rr4", 64'({core_gnt_o, sb_gnt_o}), 64'h2);
    apply(1, 0, 0, 0, 0, 0, 1, 32'h9);
    check_eq("t2_drain", 64'({core_rvalid_o, sb_rvalid_o}), 64'h2);

    // 3: core stalled by memory while SBA arrives
    apply(1, 1, 32'h200, 0, 0, 0, 0, 0);
    check_eq("t3_stall0_addr", 64'(m_addr_o), 64'h200);
    check_eq("t3_stall0_gnt",  64'({m_req_o, core_gnt_o}), 64'h2);
    apply(1, 1, 32'h200, 1, 32'h300, 0, 0, 0);
    check_eq("t3_stall1_addr", 64'(m_addr_o), 64'h200);
    check_eq("t3_stall1_sbg",  64'(sb_gnt_o), 64'h0);
    apply(1, 1, 32'h200, 1, 32'h300, 0, 0, 0);
    check_eq("t3_stall2_addr", 64'(m_addr_o), 64'h200);
    apply(1, 1, 32'h200, 1, 32'h300, 1, 0, 0);
    check_eq("t3_core_gnt", 64'({core_gnt_o, sb_gnt_o}), 64'h2);
    check_eq("t3_core_addr", 64'(m_addr_o), 64'h200);
    apply(1, 0, 0, 1, 32'h300, 1, 0, 0);
    check_eq("t3_sb_gnt",  64'({core_gnt_o, sb_gnt_o}), 64'h1);
    check_eq("t3_sb_payload", 64'({m_addr_o, m_wdata_o}), {32'h300, 32'h2222_2222});
    check_eq("t3_sb_we_be", 64'({m_we_o, m_be_o}), 64'h13);
    apply(1, 0, 0, 0, 0, 0, 1, 32'h1);
    check_eq("t3_rv_core", 64'({core_rvalid_o, sb_rvalid_o}), 64'h2);
    apply(1, 0, 0, 0, 0, 0, 1, 32'h2);
    check_eq("t3_rv_sb", 64'({core_rvalid_o, sb_rvalid_o}), 64'h1);

    // 4: fill both ID slots, then drain with A and B
    apply(1, 1, 32'h400, 1, 32'h500, 1, 0, 0);
    check_eq("t4_g_core", 64'({core_gnt_o, sb_gnt_o}), 64'h2);
    apply(1, 1, 32'h404, 1, 32'h500, 1, 0, 0);
    check_eq("t4_g_sb", 64'({core_gnt_o, sb_gnt_o}), 64'h1);
    apply(1, 1, 32'h404, 0, 0, 1, 0, 0);
    check_eq("t4_full_noreq", 64'({m_req_o, core_gnt_o}), 64'h0);
    apply(1, 1, 32'h404, 0, 0, 1, 1, 32'hAAAA_0001);
    check_eq("t4_rvA", 64'({core_rvalid_o, sb_rvalid_o}), 64'h2);
    check_eq("t4_rdataA", 64'(core_rdata_o), 64'hAAAA_0001);
    check_eq("t4_full_pop_noreq", 64'(m_req_o), 64'h0);
    apply(1, 1, 32'h404, 0, 0, 1, 1, 32'hBBBB_0002);
    check_eq("t4_rvB", 64'({core_rvalid_o, sb_rvalid_o}), 64'h1);
    check_eq("t4_rdataB", 64'(sb_rdata_o), 64'hBBBB_0002);
    check_eq("t4_req_back", 64'({m_req_o, core_gnt_o}), 64'h3);
    apply(1, 0, 0, 0, 0, 1, 1, 32'hCCCC_0003);
    check_eq("t4_rvC", 64'({core_rvalid_o, sb_rvalid_o}), 64'h2);

    // 5: response with nothing outstanding
    apply(1, 0, 0, 0, 0, 0, 1, 32'h77);
    check_eq("t5_unexp", 64'(unexp_rvalid_o), 64'h1);
    check_eq("t5_no_rv", 64'({core_rvalid_o, sb_rvalid_o}), 64'h0);
    apply(1, 0, 0, 0, 0, 0, 0, 0);
    check_eq("t5_unexp_pulse", 64'(unexp_rvalid_o), 64'h0);

    // 6: reset with two outstanding
    apply(1, 1, 32'h600, 0, 0, 1, 0, 0);
    check_eq("t6_g_core", 64'(core_gnt_o), 64'h1);
    apply(1, 0, 0, 1, 32'h700, 1, 0, 0);
    check_eq("t6_g_sb", 64'(sb_gnt_o), 64'h1);
    apply(0, 1, 32'h600, 1, 32'h700, 1, 1, 32'h55);
    check_eq("t6_rst_req",  64'({m_req_o, core_gnt_o, sb_gnt_o}), 64'h0);
    check_eq("t6_rst_rv",   64'({core_rvalid_o, sb_rvalid_o, unexp_rvalid_o}), 64'h0);
    check_eq("t6_rst_data", 64'(core_rdata_o | sb_rdata_o), 64'h0);
    apply(1, 1, 32'h600, 1, 32'h700, 1, 0, 0);
    check_eq("t6_core_wins_tie", 64'({core_gnt_o, sb_gnt_o}), 64'h2);
    check_eq("t6_fp_sb_wins",    64'({fp_core_gnt, fp_sb_gnt}), 64'h1);
    apply(1, 0, 0, 0, 0, 0, 1, 32'h66);
    check_eq("t6_post_rv", 64'({core_rvalid_o, sb_rvalid_o, unexp_rvalid_o}), 64'h4);
    apply(1, 0, 0, 0, 0, 0, 1, 32'h67);
    check_eq("t6_stale_unexp", 64'({core_rvalid_o, sb_rvalid_o, unexp_rvalid_o}), 64'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
